// File: rtl/data_bus_pkg.sv
// Shared types and constants for the data bus arbiter.
// Holds the FSM state encoding and a constant-safe clog2 helper.
package data_bus_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner search starting one past last_grant, wrapping to 0.
// Latency: combinational. Backpressure: none, pure function of inputs.
module rr_arbiter
    import data_bus_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SW       = clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SW-1:0]       last_grant,
    output logic [CHANNELS-1:0] winner,
    output logic [SW-1:0]       index,
    output logic                any
);

    int            pos;
    logic [SW-1:0] idx;

    always_comb begin
        winner = '0;
        index  = '0;
        any    = 1'b0;
        pos    = 0;
        idx    = '0;
        // Offsets 1..CHANNELS so last_grant itself is checked last.
        for (int k = 1; k <= CHANNELS; k++) begin
            pos = (int'(last_grant) + k) % CHANNELS;
            idx = SW'(pos);
            if (!any && req[idx]) begin
                any         = 1'b1;
                winner[idx] = 1'b1;
                index       = idx;
            end
        end
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Multi-channel bus arbiter: fixed-select or round-robin onto one registered word.
// Latency: 1 cycle request-to-valid; back-to-back loads on transfer without a bubble.
// Backpressure: d/grant/valid held while ready=0; inputs ignored until the transfer.
module data_bus_arbiter
    import data_bus_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SW       = clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       req,
    input  logic [CHANNELS*WIDTH-1:0] i,
    input  logic                      mode,
    input  logic [SW-1:0]             sel,
    input  logic                      ready,
    output logic [WIDTH-1:0]          d,
    output logic                      valid,
    output logic [CHANNELS-1:0]       grant
);

    state_t              state, state_nxt;
    logic [SW-1:0]       last_grant, last_grant_nxt;
    logic [WIDTH-1:0]    d_nxt;
    logic [CHANNELS-1:0] grant_nxt;
    logic                valid_nxt;

    logic [WIDTH-1:0]    chan_dat [CHANNELS];
    logic [CHANNELS-1:0] fix_oh;
    logic [CHANNELS-1:0] rr_oh;
    logic [SW-1:0]       rr_idx;
    logic                rr_any;

    logic [CHANNELS-1:0] win_oh;
    logic [SW-1:0]       win_idx;
    logic                qual;
    logic                load;

    // Widened compare keeps an out-of-range sel from matching any channel.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign chan_dat[g] = i[g*WIDTH +: WIDTH];
        assign fix_oh[g]   = ({1'b0, sel} == (SW+1)'(g));
    end

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SW       (SW)
    ) u_rr (
        .req        (req),
        .last_grant (last_grant),
        .winner     (rr_oh),
        .index      (rr_idx),
        .any        (rr_any)
    );

    always_comb begin
        win_oh  = mode ? rr_oh  : (fix_oh & req);
        win_idx = mode ? rr_idx : sel;
        qual    = mode ? rr_any : |(fix_oh & req);
        load    = qual && ((state == IDLE) || ready);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        d_nxt          = d;
        grant_nxt      = grant;
        valid_nxt      = valid;
        last_grant_nxt = last_grant;

        case (state)
            IDLE: begin
                if (qual) state_nxt = DRIVE;
            end
            DRIVE: begin
                if (ready && !qual) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    valid_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (load) begin
            d_nxt     = chan_dat[win_idx];
            grant_nxt = win_oh;
            valid_nxt = 1'b1;
            if (mode) last_grant_nxt = rr_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d          <= '0;
            grant      <= '0;
            valid      <= 1'b0;
            last_grant <= SW'(CHANNELS - 1);
        end else begin
            d          <= d_nxt;
            grant      <= grant_nxt;
            valid      <= valid_nxt;
            last_grant <= last_grant_nxt;
        end
    end

endmodule
